serial_bus_arbiter: RTL and testbench

Two-master bus arbiter for the serial bus. It grants one master at a time and drives the master-select for the bus mux. It also sequences split transactions: on a slave split it parks the current master and frees the bus for the other one, then re-grants the parked master with a split_grant pulse once the slave is ready to return data. It sits between the master ports and the address decoder/mux in the bus top level.

---
 rtl/serial_bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// -----------------------------------------------------------------------------
// serial_bus_arbiter
//
// Two-master arbiter for the serial bus. Grants one master at a time, drives
// the master-select for the bus mux, and sequences split transactions: when a
// slave signals a split the current owner is parked and the bus is freed for
// the other master; once the slave drops its split indication the parked
// master is re-granted together with a one-cycle split_grant pulse.
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   : in IDLE, a contended grant goes to the master that did not win
//               the last normal grant (split resumes do not count)
//   undefined : fixed priority, master 0 over master 1
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rstn         in   1  asynchronous active-low reset
//   breq         in   2  per-master bus request, held for the whole transaction
//   ssplit       in   1  OR of all slave split indications (level)
//   bgrant       out  2  one-hot registered grant per master
//   msel         out  1  index of the granted master (holds while bgrant=0)
//   bbusy        out  1  high when any bgrant bit is high
//   msplit       out  2  per-master "parked in a split" flag
//   split_grant  out  1  one-cycle pulse: parked master re-granted
//   split_err    out  1  sticky: a second split arrived while one was pending
// -----------------------------------------------------------------------------
module serial_bus_arbiter #(
   parameter int NUM_MASTERS   = 2,
   parameter bit SPLIT_SUPPORT = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] breq,
   input  logic       ssplit,
   output logic [1:0] bgrant,
   output logic       msel,
   output logic       bbusy,
   output logic [1:0] msplit,
   output logic       split_grant,
   output logic       split_err
);

   if (NUM_MASTERS != 2) begin : g_num_masters_check
      $error("serial_bus_arbiter supports exactly 2 masters");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_SGRANT = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic       split_pend_r;
   logic       split_pend_s;
   logic       split_owner_r;
   logic       split_owner_s;
   logic       ssplit_d_r;
   logic [1:0] bgrant_s;
   logic       msel_s;
   logic       bbusy_s;
   logic [1:0] msplit_s;
   logic       split_grant_s;
   logic       split_err_s;
   logic [1:0] req_s;
   logic       winner_s;
   logic       split_ev_s;
`ifdef ROUND_ROBIN_EN
   logic       last_winner_r;
   logic       last_winner_s;
`endif

   // Master index to one-hot grant vector.
   function automatic logic [1:0] idx2oh(input logic idx);
      if (idx) begin
         return 2'b10;
      end else begin
         return 2'b01;
      end
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_s       = state_r;
      split_pend_s  = split_pend_r;
      split_owner_s = split_owner_r;
      bgrant_s      = bgrant;
      msel_s        = msel;
      bbusy_s       = bbusy;
      msplit_s      = msplit;
      split_grant_s = 1'b0;
      split_err_s   = split_err;
`ifdef ROUND_ROBIN_EN
      last_winner_s = last_winner_r;
`endif

      // The parked master keeps requesting but must not win a normal grant.
      if (split_pend_r) begin
         req_s = breq & ~idx2oh(split_owner_r);
      end else begin
         req_s = breq;
      end

      split_ev_s = (SPLIT_SUPPORT == 1'b1) && ssplit && !ssplit_d_r;

`ifdef ROUND_ROBIN_EN
      if (req_s == 2'b11) begin
         winner_s = ~last_winner_r;
      end else if (req_s[1]) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
`else
      if (req_s[0]) begin
         winner_s = 1'b0;
      end else if (req_s[1]) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
`endif

      case (state_r)
         ST_IDLE: begin
            if ((SPLIT_SUPPORT == 1'b1) && split_pend_r && !ssplit) begin
               state_s       = ST_SGRANT;
               bgrant_s      = idx2oh(split_owner_r);
               msel_s        = split_owner_r;
               split_grant_s = 1'b1;
            end else if (req_s != 2'b00) begin
               state_s  = ST_BUSY;
               bgrant_s = idx2oh(winner_s);
               msel_s   = winner_s;
`ifdef ROUND_ROBIN_EN
               last_winner_s = winner_s;
`endif
            end else begin
               state_s  = ST_IDLE;
               bgrant_s = 2'b00;
            end
         end
         ST_SGRANT: begin
            state_s               = ST_BUSY;
            msplit_s[split_owner_r] = 1'b0;
            split_pend_s          = 1'b0;
         end
         ST_BUSY: begin
            // A new split wins over a simultaneous request drop.
            if (split_ev_s && !split_pend_r) begin
               state_s          = ST_IDLE;
               bgrant_s         = 2'b00;
               msplit_s[msel]   = 1'b1;
               split_pend_s     = 1'b1;
               split_owner_s    = msel;
            end else begin
               if (split_ev_s) begin
                  split_err_s = 1'b1;
               end else begin
                  split_err_s = split_err;
               end
               if (!breq[msel]) begin
                  state_s  = ST_IDLE;
                  bgrant_s = 2'b00;
               end else begin
                  state_s  = ST_BUSY;
               end
            end
         end
         default: begin
            state_s  = ST_IDLE;
            bgrant_s = 2'b00;
         end
      endcase

      bbusy_s = |bgrant_s;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= ST_IDLE;
         split_pend_r  <= 1'b0;
         split_owner_r <= 1'b0;
         ssplit_d_r    <= 1'b0;
         bgrant        <= 2'b00;
         msel          <= 1'b0;
         bbusy         <= 1'b0;
         msplit        <= 2'b00;
         split_grant   <= 1'b0;
         split_err     <= 1'b0;
      end else begin
         state_r       <= state_s;
         split_pend_r  <= split_pend_s;
         split_owner_r <= split_owner_s;
         ssplit_d_r    <= ssplit;
         bgrant        <= bgrant_s;
         msel          <= msel_s;
         bbusy         <= bbusy_s;
         msplit        <= msplit_s;
         split_grant   <= split_grant_s;
         split_err     <= split_err_s;
      end
   end

`ifdef ROUND_ROBIN_EN
   // Last normal-grant winner; resets to 1 so master 0 wins first.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_winner_r <= 1'b1;
      end else begin
         last_winner_r <= last_winner_s;
      end
   end
`endif

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_bus_arbiter
//
// Table-driven bench for serial_bus_arbiter. Each record holds the inputs for
// one clock and the outputs expected right after that edge, packed as
// {bgrant[1:0], msel, bbusy, msplit[1:0], split_grant, split_err}.
// A hand-written sequence covers the asynchronous reset with a pending split.
// -----------------------------------------------------------------------------
module tb_serial_bus_arbiter;

   typedef struct packed {
      logic [1:0] breq;
      logic       ssplit;
      logic [7:0] exp;
   } vec_t;

`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk;
   logic       rstn;
   logic [1:0] breq;
   logic       ssplit;
   logic [1:0] bgrant;
   logic       msel;
   logic       bbusy;
   logic [1:0] msplit;
   logic       split_grant;
   logic       split_err;

   int total;
   int bad;
   vec_t vecs[$];

   serial_bus_arbiter dut (
      .clk         (clk),
      .rstn        (rstn),
      .breq        (breq),
      .ssplit      (ssplit),
      .bgrant      (bgrant),
      .msel        (msel),
      .bbusy       (bbusy),
      .msplit      (msplit),
      .split_grant (split_grant),
      .split_err   (split_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic v(input logic [1:0] b, input logic s, input logic [1:0] g,
                    input logic m, input logic bb, input logic [1:0] ms,
                    input logic sg, input logic se);
      vec_t r;
      r.breq   = b;
      r.ssplit = s;
      r.exp    = {g, m, bb, ms, sg, se};
      vecs.push_back(r);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] got;
      got = {bgrant, msel, bbusy, msplit, split_grant, split_err};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {bgrant,msel,bbusy,msplit,sg,se}=%b required %b",
                  name, got, exp);
      end
   endtask

   initial begin
      logic [1:0] g1;
      logic [1:0] l1;
      total = 0;
      bad   = 0;

      // First contention winner depends on the arbitration policy.
      g1 = RR ? 2'b10 : 2'b01;
      l1 = ~g1;

      // Single request held then dropped; one idle cycle follows.
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      v(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      // Contention, winner drops, turnaround gap, loser granted.
      v(2'b11, 1'b0, g1,    g1[1], 1'b1, 2'b00, 1'b0, 1'b0);
      v(l1,    1'b0, 2'b00, g1[1], 1'b0, 2'b00, 1'b0, 1'b0);
      v(l1,    1'b0, l1,    l1[1], 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b00, 1'b0, 2'b00, l1[1], 1'b0, 2'b00, 1'b0, 1'b0);
      v(2'b00, 1'b0, 2'b00, l1[1], 1'b0, 2'b00, 1'b0, 1'b0);
      // Master 0 owns the bus, split parks it, master 1 takes over.
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      v(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
      v(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
      v(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
      v(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
      v(2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
      // Second split while one is pending: sticky error, grant kept.
      v(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
      v(2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
      // Master 1 finishes, turnaround, then split resume with pulse.
      v(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
      v(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
      // Request drop and split in the same cycle: split wins.
      v(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
      v(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
      // Master 1 granted while master 0 stays parked.
      v(2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);

      // Reset values.
      rstn   = 1'b0;
      breq   = 2'b00;
      ssplit = 1'b0;
      tick();
      tick();
      check("reset_state", 8'b0000_0000);
      rstn = 1'b1;

      foreach (vecs[i]) begin
         breq   = vecs[i].breq;
         ssplit = vecs[i].ssplit;
         tick();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Asynchronous reset mid-transaction with a pending split.
      rstn = 1'b0;
      #1;
      check("async_reset_immediate", 8'b0000_0000);
      tick();
      check("async_reset_held", 8'b0000_0000);
      breq   = 2'b10;
      ssplit = 1'b0;
      rstn   = 1'b1;
      tick();
      check("post_reset_grant", 8'b1011_0000);
      tick();
      check("post_reset_no_resume", 8'b1011_0000);
      breq = 2'b00;
      tick();
      check("post_reset_drop", 8'b0010_0000);
      tick();
      check("post_reset_idle", 8'b0010_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
